rv32_decode_stage: RTL and testbench
====================================

# rv32_decode_stage

Parametrised, elastic RV32 decode stage sitting between fetch and register-read/execute. It registers one decoded micro-op per cycle behind a valid/ready handshake with a one-entry skid buffer, so fetch never needs a combinational path from execute back-pressure. Beyond the base RV32I decode it adds:
- optional M-extension recognition;
- illegal-instruction flagging;
- return-address-stack (RAS) hints;
- pipeline flush.

## Interface
- XLEN, 32, datapath / PC width (≥32)
- REG_BITS, 5, register address width
- ENABLE_M, 1, 1 = decode OP funct7=0000001 as MUL path; 0 = flag it illegal
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous assert, active-low
- flush_i  in  1  drop all held and incoming instructions
- valid_i  in  1  instr_i/pc_i valid
- ready_o  out  1  stage can accept
- instr_i  in  32  raw instruction
- pc_i  in  XLEN  PC of instr_i
- valid_o  out  1  decoded op valid
- ready_i  in  1  downstream accepts
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  REG_BITS  0 when operand unused
- imm_o  out  XLEN  selected, sign-extended immediate
- imm_valid_o  out  1  ALU op2 is imm_o
- alu_op_o  out  4  {funct7[5] for OP/shift-imm, funct3}; 0 for U/J/JALR/B/L/S
- size_o  out  3  funct3 for loads/stores
- path_o  out  3  one-hot: 001 ALU, 010 MEM, 100 MUL
- mem_write_o, branch_o, jal_o, jalr_o, link_o  out  1  op-class flags
- branch_cond_o  out  3  funct3 for branches
- target_o  out  XLEN  pc+J-imm (JAL), pc+B-imm (branch)
- link_data_o  out  XLEN  pc+4
- push_ras_o, pop_ras_o  out  1  RAS hints
- illegal_o  out  1  instruction not decodable
- pc_o  out  XLEN  PC of decoded op

## Operation
**Storage:** output register (OUT) plus skid register (SKID), each with a valid bit. Decode logic is purely combinational from instr_i/pc_i and is captured into whichever register receives the op. SKID holds a fully decoded bundle.

**Handshake:**
- ready_o = ~skid_valid.
- Transfer in when valid_i & ready_o.
- Transfer out when valid_o & ready_i.
- valid_o = out_valid.

**Register update, per cycle:**
- OUT empty or draining:
  - SKID holds an op → SKID moves to OUT.
  - else an incoming op → goes to OUT.
- OUT held and an incoming op arrives → the op goes to SKID.
- Order is always preserved.

**Instruction encodings (opcode[6:2]):**
- I-type: L, AI, JALR, SYS.
- S-type: S.
- R-type: OP.
- U-type: LUI, AUIPC.
- B-type: B.
- J-type: JAL.
- FENCE decodes as an ALU no-op: rd=0, imm_valid=1, imm=0.

**Immediates:** sign-extended to XLEN per the ISA.
- LUI: imm = {u, 12'b0}.
- AUIPC: imm = pc + {u, 12'b0}.
- Arithmetic wraps modulo 2^XLEN.

**Illegal instruction:** illegal_o=1 when any of the following holds:
- instr[1:0] != 11;
- unlisted opcode;
- OP with funct7 ∉ {0000000, 0100000, 0000001};
- funct7=0000001 with ENABLE_M=0.

An illegal op still flows as valid with all other flags 0 and all addresses 0.

**RAS hints:** link register = x1 or x5.
- JAL with rd=link → push.
- JALR:
  - rd=link, rs1≠link → push;
  - rd≠link, rs1=link → pop;
  - both link, rd≠rs1 → pop+push;
  - both link, rd==rs1 → push only.

## Timing
- Latency: instruction accepted in cycle N appears on outputs in cycle N+1 when OUT is empty or draining.
- Throughput: one op per cycle with ready_i held high.
- Back-pressure: if ready_i=0 while an op is in OUT, one further op is absorbed into SKID, then ready_o=0 from the following cycle. ready_o returns high the cycle after SKID drains.
- Flush:
  - flush_i=1 clears out_valid and skid_valid at the next edge;
  - a same-cycle valid_i is discarded;
  - ready_o is 1 in the cycle after a flush.
  - flush takes priority over every transfer.
- Reset:
  - rstn_i low clears out_valid and skid_valid asynchronously;
  - all flags, addresses, imm_o and pc_o reset to 0; ready_o=1.
  - Reset asserted mid-stall loses all held ops.
  - Deassertion is synchronised externally.
- Data outputs are stable while valid_o=1 and ready_i=0.

## Test plan
1. ADDI: 0xFFF00093 at pc=0x100 → next cycle valid_o=1, rd=1, rs1=0, imm_o=0xFFFFFFFF, imm_valid=1, path=001, illegal=0.
2. JAL: 0x008000EF at pc=0x200 → jal_o=1, target_o=0x208, link_data_o=0x204, push_ras_o=1, pop_ras_o=0, rd=1; JALR 0x00008067 (rs1=x1, rd=x0) → pop_ras_o=1, push_ras_o=0.
3. Back-pressure: ready_i=0; present three consecutive valid instructions → first two accepted, ready_o=0 from the cycle after the second; raise ready_i → ops emerge in order on consecutive cycles, third is then accepted.
4. MUL 0x02208033: with ENABLE_M=1 → path=100, rs1=1, rs2=2; with ENABLE_M=0 → illegal_o=1, path=001, all addresses 0.
5. Flush with OUT and SKID both full plus valid_i=1 → next cycle valid_o=0, ready_o=1, and no flushed op ever appears.
6. Async reset mid-stall: drop rstn_i between clock edges → valid_o=0 immediately; after release, AUIPC 0x00001097 at pc=0x40 → imm_o=0x1040, rd=1.

Source files
------------

// File: rtl/rv32_decode_stage.sv
// Elastic RV32 decode stage: combinational decode captured into an output
// register backed by a one-entry skid register, so ready_o never depends on ready_i.
module rv32_decode_stage #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned REG_BITS = 5,
   parameter bit          ENABLE_M = 1'b1
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                flush_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [31:0]         instr_i,
   input  logic [XLEN-1:0]     pc_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [REG_BITS-1:0] rs1_addr_o,
   output logic [REG_BITS-1:0] rs2_addr_o,
   output logic [REG_BITS-1:0] rd_addr_o,
   output logic [XLEN-1:0]     imm_o,
   output logic                imm_valid_o,
   output logic [3:0]          alu_op_o,
   output logic [2:0]          size_o,
   output logic [2:0]          path_o,
   output logic                mem_write_o,
   output logic                branch_o,
   output logic                jal_o,
   output logic                jalr_o,
   output logic                link_o,
   output logic [2:0]          branch_cond_o,
   output logic [XLEN-1:0]     target_o,
   output logic [XLEN-1:0]     link_data_o,
   output logic                push_ras_o,
   output logic                pop_ras_o,
   output logic                illegal_o,
   output logic [XLEN-1:0]     pc_o
);

   typedef enum logic [4:0] {
      OPC_LOAD     = 5'b00000,
      OPC_MISC_MEM = 5'b00011,
      OPC_OP_IMM   = 5'b00100,
      OPC_AUIPC    = 5'b00101,
      OPC_STORE    = 5'b01000,
      OPC_OP       = 5'b01100,
      OPC_LUI      = 5'b01101,
      OPC_BRANCH   = 5'b11000,
      OPC_JALR     = 5'b11001,
      OPC_JAL      = 5'b11011,
      OPC_SYSTEM   = 5'b11100
   } opcode_e;

   localparam logic [2:0] PATH_ALU = 3'b001;
   localparam logic [2:0] PATH_MEM = 3'b010;
   localparam logic [2:0] PATH_MUL = 3'b100;

   typedef struct packed {
      logic [REG_BITS-1:0] rs1;
      logic [REG_BITS-1:0] rs2;
      logic [REG_BITS-1:0] rd;
      logic [XLEN-1:0]     imm;
      logic                imm_valid;
      logic [3:0]          alu_op;
      logic [2:0]          size;
      logic [2:0]          path;
      logic                mem_write;
      logic                branch;
      logic                jal;
      logic                jalr;
      logic                link;
      logic [2:0]          branch_cond;
      logic [XLEN-1:0]     target;
      logic [XLEN-1:0]     link_data;
      logic                push_ras;
      logic                pop_ras;
      logic                illegal;
      logic [XLEN-1:0]     pc;
   } uop_t;

   logic [4:0]      rs1_f, rs2_f, rd_f;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            rd_is_link, rs1_is_link;
   logic            illegal;
   uop_t            dec;

   uop_t out_q, out_d, skid_q, skid_d;
   logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
   logic take_in, out_free;

   assign rs1_f  = instr_i[19:15];
   assign rs2_f  = instr_i[24:20];
   assign rd_f   = instr_i[11:7];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   assign imm_i = XLEN'($signed(instr_i[31:20]));
   assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
   assign imm_b = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

   assign rd_is_link  = (rd_f == 5'd1) || (rd_f == 5'd5);
   assign rs1_is_link = (rs1_f == 5'd1) || (rs1_f == 5'd5);

   always_comb begin
      dec           = '0;
      illegal       = 1'b0;
      dec.pc        = pc_i;
      dec.link_data = pc_i + XLEN'(4);
      dec.path      = PATH_ALU;
      if (instr_i[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (instr_i[6:2])
            OPC_LOAD: begin
               dec.rs1       = REG_BITS'(rs1_f);
               dec.rd        = REG_BITS'(rd_f);
               dec.imm       = imm_i;
               dec.imm_valid = 1'b1;
               dec.path      = PATH_MEM;
               dec.size      = funct3;
            end
            OPC_MISC_MEM: begin
               dec.imm_valid = 1'b1;
            end
            OPC_OP_IMM: begin
               dec.rs1       = REG_BITS'(rs1_f);
               dec.rd        = REG_BITS'(rd_f);
               dec.imm       = imm_i;
               dec.imm_valid = 1'b1;
               // funct7[5] only carries meaning for the shift-immediate forms
               dec.alu_op    = {(funct3[1:0] == 2'b01) & instr_i[30], funct3};
            end
            OPC_AUIPC: begin
               dec.rd        = REG_BITS'(rd_f);
               dec.imm       = pc_i + imm_u;
               dec.imm_valid = 1'b1;
            end
            OPC_STORE: begin
               dec.rs1       = REG_BITS'(rs1_f);
               dec.rs2       = REG_BITS'(rs2_f);
               dec.imm       = imm_s;
               dec.imm_valid = 1'b1;
               dec.path      = PATH_MEM;
               dec.mem_write = 1'b1;
               dec.size      = funct3;
            end
            OPC_OP: begin
               if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000) ||
                   ((funct7 == 7'b0000001) && ENABLE_M)) begin
                  dec.rs1    = REG_BITS'(rs1_f);
                  dec.rs2    = REG_BITS'(rs2_f);
                  dec.rd     = REG_BITS'(rd_f);
                  dec.alu_op = {instr_i[30], funct3};
                  dec.path   = (funct7 == 7'b0000001) ? PATH_MUL : PATH_ALU;
               end else begin
                  illegal = 1'b1;
               end
            end
            OPC_LUI: begin
               dec.rd        = REG_BITS'(rd_f);
               dec.imm       = imm_u;
               dec.imm_valid = 1'b1;
            end
            OPC_BRANCH: begin
               dec.rs1         = REG_BITS'(rs1_f);
               dec.rs2         = REG_BITS'(rs2_f);
               dec.imm         = imm_b;
               dec.branch      = 1'b1;
               dec.branch_cond = funct3;
               dec.target      = pc_i + imm_b;
            end
            OPC_JALR: begin
               dec.rs1       = REG_BITS'(rs1_f);
               dec.rd        = REG_BITS'(rd_f);
               dec.imm       = imm_i;
               dec.imm_valid = 1'b1;
               dec.jalr      = 1'b1;
               dec.link      = 1'b1;
               case ({rd_is_link, rs1_is_link})
                  2'b10:   dec.push_ras = 1'b1;
                  2'b01:   dec.pop_ras  = 1'b1;
                  2'b11: begin
                     dec.push_ras = 1'b1;
                     dec.pop_ras  = (rd_f != rs1_f);
                  end
                  default: ;
               endcase
            end
            OPC_JAL: begin
               dec.rd       = REG_BITS'(rd_f);
               dec.imm      = imm_j;
               dec.jal      = 1'b1;
               dec.link     = 1'b1;
               dec.target   = pc_i + imm_j;
               dec.push_ras = rd_is_link;
            end
            OPC_SYSTEM: begin
               dec.rs1       = REG_BITS'(rs1_f);
               dec.rd        = REG_BITS'(rd_f);
               dec.imm       = imm_i;
               dec.imm_valid = 1'b1;
               dec.alu_op    = {1'b0, funct3};
            end
            default: illegal = 1'b1;
         endcase
      end
      if (illegal) begin
         dec           = '0;
         dec.pc        = pc_i;
         dec.link_data = pc_i + XLEN'(4);
         dec.path      = PATH_ALU;
         dec.illegal   = 1'b1;
      end
   end

   assign take_in  = valid_i & ~skid_vld_q;
   assign out_free = ~out_vld_q | ready_i;

   // SKID is only ever occupied while OUT is, so draining it first keeps order
   always_comb begin
      out_d      = out_q;
      skid_d     = skid_q;
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush_i) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (out_free) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else if (take_in) begin
            out_d     = dec;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (take_in) begin
         skid_d     = dec;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign ready_o       = ~skid_vld_q;
   assign valid_o       = out_vld_q;
   assign rs1_addr_o    = out_q.rs1;
   assign rs2_addr_o    = out_q.rs2;
   assign rd_addr_o     = out_q.rd;
   assign imm_o         = out_q.imm;
   assign imm_valid_o   = out_q.imm_valid;
   assign alu_op_o      = out_q.alu_op;
   assign size_o        = out_q.size;
   assign path_o        = out_q.path;
   assign mem_write_o   = out_q.mem_write;
   assign branch_o      = out_q.branch;
   assign jal_o         = out_q.jal;
   assign jalr_o        = out_q.jalr;
   assign link_o        = out_q.link;
   assign branch_cond_o = out_q.branch_cond;
   assign target_o      = out_q.target;
   assign link_data_o   = out_q.link_data;
   assign push_ras_o    = out_q.push_ras;
   assign pop_ras_o     = out_q.pop_ras;
   assign illegal_o     = out_q.illegal;
   assign pc_o          = out_q.pc;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: a two-deep queue model plus an ISA-level decoder,
// checked every cycle against instances built with and without the M extension.
module tb_rv32_decode_stage;

   typedef struct packed {
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic        immv;
      logic [3:0]  alu;
      logic [2:0]  size, path;
      logic        memw, br, jal, jalr, link;
      logic [2:0]  cond;
      logic [31:0] target, linkd;
      logic        push, pop, ill;
      logic [31:0] pc;
   } op_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   logic        clk, rstn, flush, vin, rdy;
   logic [31:0] instr, pc;

   logic        ready_1, valid_1, immv_1, memw_1, br_1, jal_1, jalr_1, link_1, push_1, pop_1, ill_1;
   logic [4:0]  rs1_1, rs2_1, rd_1;
   logic [31:0] imm_1, target_1, linkd_1, pco_1;
   logic [3:0]  alu_1;
   logic [2:0]  size_1, path_1, cond_1;
   logic        ready_0, valid_0, immv_0, memw_0, br_0, jal_0, jalr_0, link_0, push_0, pop_0, ill_0;
   logic [4:0]  rs1_0, rs2_0, rd_0;
   logic [31:0] imm_0, target_0, linkd_0, pco_0;
   logic [3:0]  alu_0;
   logic [2:0]  size_0, path_0, cond_0;
   op_t         got1, got0;

   int          n_vec = 0;
   int          n_err = 0;
   ent_t        q[$];
   bit          do_pop, do_push, acc;
   int          w;
   logic [31:0] tbl [0:13];
   op_t         pin;

   rv32_decode_stage #(.XLEN(32), .REG_BITS(5), .ENABLE_M(1'b1)) dut1 (
      .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(vin), .ready_o(ready_1),
      .instr_i(instr), .pc_i(pc), .valid_o(valid_1), .ready_i(rdy),
      .rs1_addr_o(rs1_1), .rs2_addr_o(rs2_1), .rd_addr_o(rd_1), .imm_o(imm_1),
      .imm_valid_o(immv_1), .alu_op_o(alu_1), .size_o(size_1), .path_o(path_1),
      .mem_write_o(memw_1), .branch_o(br_1), .jal_o(jal_1), .jalr_o(jalr_1), .link_o(link_1),
      .branch_cond_o(cond_1), .target_o(target_1), .link_data_o(linkd_1),
      .push_ras_o(push_1), .pop_ras_o(pop_1), .illegal_o(ill_1), .pc_o(pco_1));

   rv32_decode_stage #(.XLEN(32), .REG_BITS(5), .ENABLE_M(1'b0)) dut0 (
      .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(vin), .ready_o(ready_0),
      .instr_i(instr), .pc_i(pc), .valid_o(valid_0), .ready_i(rdy),
      .rs1_addr_o(rs1_0), .rs2_addr_o(rs2_0), .rd_addr_o(rd_0), .imm_o(imm_0),
      .imm_valid_o(immv_0), .alu_op_o(alu_0), .size_o(size_0), .path_o(path_0),
      .mem_write_o(memw_0), .branch_o(br_0), .jal_o(jal_0), .jalr_o(jalr_0), .link_o(link_0),
      .branch_cond_o(cond_0), .target_o(target_0), .link_data_o(linkd_0),
      .push_ras_o(push_0), .pop_ras_o(pop_0), .illegal_o(ill_0), .pc_o(pco_0));

   assign got1 = {rs1_1, rs2_1, rd_1, imm_1, immv_1, alu_1, size_1, path_1, memw_1, br_1,
                  jal_1, jalr_1, link_1, cond_1, target_1, linkd_1, push_1, pop_1, ill_1, pco_1};
   assign got0 = {rs1_0, rs2_0, rd_0, imm_0, immv_0, alu_0, size_0, path_0, memw_0, br_0,
                  jal_0, jalr_0, link_0, cond_0, target_0, linkd_0, push_0, pop_0, ill_0, pco_0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   // ISA-level reference decode, organised by full 7-bit opcode
   function automatic op_t ref_decode(input logic [31:0] ins, input logic [31:0] p, input bit m);
      op_t         o;
      logic [2:0]  f3 = ins[14:12];
      logic [6:0]  f7 = ins[31:25];
      logic [4:0]  rd = ins[11:7];
      logic [4:0]  r1 = ins[19:15];
      logic [4:0]  r2 = ins[24:20];
      logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
      logic [31:0] is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      logic [31:0] ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      logic [31:0] iu = {ins[31:12], 12'h000};
      logic [31:0] ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      bit          bad = (ins[1:0] != 2'b11);
      o = '0;
      o.pc = p; o.linkd = p + 32'd4; o.path = 3'b001;
      if (!bad) begin
         case (ins[6:0])
            7'h03: begin o.rs1 = r1; o.rd = rd; o.imm = ii; o.immv = 1; o.path = 3'b010; o.size = f3; end
            7'h0F: o.immv = 1;
            7'h13: begin o.rs1 = r1; o.rd = rd; o.imm = ii; o.immv = 1;
                         o.alu = {(f3 == 3'd1 || f3 == 3'd5) ? ins[30] : 1'b0, f3}; end
            7'h17: begin o.rd = rd; o.imm = p + iu; o.immv = 1; end
            7'h23: begin o.rs1 = r1; o.rs2 = r2; o.imm = is; o.immv = 1; o.path = 3'b010;
                         o.memw = 1; o.size = f3; end
            7'h33: begin
               if (!(f7 == 7'h00 || f7 == 7'h20 || (f7 == 7'h01 && m))) bad = 1;
               else begin
                  o.rs1 = r1; o.rs2 = r2; o.rd = rd; o.alu = {ins[30], f3};
                  o.path = (f7 == 7'h01) ? 3'b100 : 3'b001;
               end
            end
            7'h37: begin o.rd = rd; o.imm = iu; o.immv = 1; end
            7'h63: begin o.rs1 = r1; o.rs2 = r2; o.imm = ib; o.br = 1; o.cond = f3; o.target = p + ib; end
            7'h67: begin
               o.rs1 = r1; o.rd = rd; o.imm = ii; o.immv = 1; o.jalr = 1; o.link = 1;
               o.push = is_link(rd);
               o.pop  = is_link(r1) && !(is_link(rd) && rd == r1);
            end
            7'h6F: begin o.rd = rd; o.imm = ij; o.jal = 1; o.link = 1; o.target = p + ij;
                         o.push = is_link(rd); end
            7'h73: begin o.rs1 = r1; o.rd = rd; o.imm = ii; o.immv = 1; o.alu = {1'b0, f3}; end
            default: bad = 1;
         endcase
      end
      if (bad) begin
         o = '0;
         o.pc = p; o.linkd = p + 32'd4; o.path = 3'b001; o.ill = 1;
      end
      return o;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic chkop(input string nm, input op_t act, input op_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Capacity-two in-order queue: ready while fewer than two held, valid while any held
   always @(posedge clk or negedge rstn) begin
      if (!rstn || flush) begin
         q.delete();
      end else begin
         do_pop  = (q.size() > 0) && rdy;
         do_push = vin && (q.size() < 2);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back('{instr: instr, pc: pc});
      end
   end

   always @(negedge clk) begin
      chk("ready_m1", 64'(ready_1), 64'(q.size() < 2));
      chk("valid_m1", 64'(valid_1), 64'(q.size() > 0));
      chk("ready_m0", 64'(ready_0), 64'(q.size() < 2));
      chk("valid_m0", 64'(valid_0), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chkop("uop_m1", got1, ref_decode(q[0].instr, q[0].pc, 1'b1));
         chkop("uop_m0", got0, ref_decode(q[0].instr, q[0].pc, 1'b0));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{32'h0040A103, 32'h0020A423, 32'hFE208EE3, 32'h123450B7, 32'h4030D093,
              32'h402081B3, 32'h00000073, 32'h0FF0000F, 32'h00000001, 32'h0000007F,
              32'h04208033, 32'h000280E7, 32'h000080E7, 32'h000002EF};
      rstn = 0; flush = 0; vin = 0; instr = '0; pc = '0; rdy = 0;

      pin = ref_decode(32'hFE208EE3, 32'h1000, 1'b1);
      chk("pin_beq_target", 64'(pin.target), 64'h0FFC);
      pin = ref_decode(32'h000280E7, 32'h0, 1'b1);
      chk("pin_jalr_pushpop", 64'({pin.push, pin.pop}), 64'h3);
      pin = ref_decode(32'h4030D093, 32'h0, 1'b1);
      chk("pin_srai_alu", 64'(pin.alu), 64'hD);
      pin = ref_decode(32'h123450B7, 32'h0, 1'b1);
      chk("pin_lui_imm", 64'(pin.imm), 64'h12345000);

      repeat (2) step();
      chk("rst_valid", 64'(valid_1), 64'h0);
      chk("rst_ready", 64'(ready_1), 64'h1);
      chk("rst_rd", 64'(rd_1), 64'h0);
      chk("rst_imm", 64'(imm_1), 64'h0);
      chk("rst_pc", 64'(pco_1), 64'h0);
      chk("rst_path", 64'(path_1), 64'h0);
      chk("rst_flags", 64'({push_1, pop_1, ill_1, jal_1, jalr_1}), 64'h0);
      #2 rstn = 1;
      step();

      // ADDI x1, x0, -1
      rdy = 1; vin = 1; instr = 32'hFFF00093; pc = 32'h100;
      step();
      chk("addi_valid", 64'(valid_1), 64'h1);
      chk("addi_rd", 64'(rd_1), 64'h1);
      chk("addi_rs1", 64'(rs1_1), 64'h0);
      chk("addi_imm", 64'(imm_1), 64'hFFFFFFFF);
      chk("addi_immv", 64'(immv_1), 64'h1);
      chk("addi_path", 64'(path_1), 64'h1);
      chk("addi_ill", 64'(ill_1), 64'h0);

      instr = 32'h008000EF; pc = 32'h200;
      step();
      chk("jal_flag", 64'(jal_1), 64'h1);
      chk("jal_target", 64'(target_1), 64'h208);
      chk("jal_link", 64'(linkd_1), 64'h204);
      chk("jal_ras", 64'({push_1, pop_1}), 64'h2);
      chk("jal_rd", 64'(rd_1), 64'h1);

      instr = 32'h00008067; pc = 32'h204;
      step();
      chk("jalr_ras", 64'({push_1, pop_1}), 64'h1);

      instr = 32'h02208033; pc = 32'h208;
      step();
      vin = 0;
      chk("mul_path_m1", 64'(path_1), 64'h4);
      chk("mul_rs_m1", 64'({rs1_1, rs2_1}), 64'({5'd1, 5'd2}));
      chk("mul_ill_m0", 64'(ill_0), 64'h1);
      chk("mul_path_m0", 64'(path_0), 64'h1);
      chk("mul_addr_m0", 64'({rs1_0, rs2_0, rd_0}), 64'h0);
      step();

      // back-pressure: A to OUT, B to SKID, C waits
      rdy = 0; vin = 1; instr = 32'h00500193; pc = 32'h300;
      step();
      chk("bp_ready_a", 64'(ready_1), 64'h1);
      instr = 32'h00A00213; pc = 32'h304;
      step();
      chk("bp_ready_b", 64'(ready_1), 64'h0);
      instr = 32'h00F00293; pc = 32'h308;
      step();
      chk("bp_hold_pc", 64'(pco_1), 64'h300);
      chk("bp_hold_ready", 64'(ready_1), 64'h0);
      rdy = 1;
      step();
      chk("bp_second_pc", 64'(pco_1), 64'h304);
      chk("bp_ready_back", 64'(ready_1), 64'h1);
      step();
      chk("bp_third_pc", 64'(pco_1), 64'h308);
      vin = 0;
      step();
      chk("bp_empty", 64'(valid_1), 64'h0);

      // flush with OUT and SKID full and a same-cycle incoming op
      rdy = 0; vin = 1; instr = 32'h00100313; pc = 32'h400;
      step();
      instr = 32'h00200393; pc = 32'h404;
      step();
      instr = 32'h00300413; pc = 32'h408; flush = 1;
      step();
      flush = 0; vin = 0;
      chk("flush_valid", 64'(valid_1), 64'h0);
      chk("flush_ready", 64'(ready_1), 64'h1);
      rdy = 1;
      repeat (3) step();
      chk("flush_nothing", 64'(valid_1), 64'h0);

      // asynchronous reset while stalled
      rdy = 0; vin = 1; instr = 32'h00100493; pc = 32'h500;
      step();
      instr = 32'h00200513; pc = 32'h504;
      step();
      vin = 0;
      #2 rstn = 0;
      #1;
      chk("arst_valid", 64'({valid_1, valid_0}), 64'h0);
      chk("arst_ready", 64'(ready_1), 64'h1);
      chk("arst_pc", 64'(pco_1), 64'h0);
      step();
      rstn = 1;
      step();
      rdy = 1; vin = 1; instr = 32'h00001097; pc = 32'h40;
      step();
      vin = 0;
      chk("auipc_imm", 64'(imm_1), 64'h1040);
      chk("auipc_rd", 64'(rd_1), 64'h1);
      step();

      // directed table under an irregular ready_i pattern
      for (int i = 0; i < 14; i++) begin
         vin = 1; instr = tbl[i]; pc = 32'h1000 + 32'(4 * i);
         w = 0; acc = 0;
         while (!acc && w < 20) begin
            rdy = ((i + w) % 3) != 0;
            acc = ready_1;
            step();
            w++;
         end
         if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept of %h", tbl[i]);
         end
      end
      vin = 0; rdy = 1;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
